display_scan_ctrl: RTL
======================

# display_scan_ctrl

Time-multiplexed scan controller for the 2-of-5 seven-segment display path. It holds `N_DIGITS` 2-of-5 digit codes written by upstream logic and presents one code at a time to the shared 2-of-5 segment decoder. It drives that decoder's E1..E5 and S3 inputs and the active-low digit anodes. It also inserts a dead cycle between digits to suppress ghosting, and flags digits whose code is not a valid 2-of-5 word.

## Interface
- `N_DIGITS`, 4, number of multiplexed digits (2..8)
- `PRESCALE`, 50000, clock cycles per digit slot (≥ 2)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `wr_en`  in  1  write strobe, one digit per cycle
- `wr_addr`  in  $clog2(N_DIGITS)  digit index; values ≥ N_DIGITS ignored
- `wr_code`  in  5  2-of-5 code, bit 4 = E1 … bit 0 = E5
- `blank`  in  1  global blank: all anodes off while high
- `clr`  in  1  synchronous clear of all digits (unloaded)
- `e_out`  out  5  to decoder E1..E5 (bit 4 = E1)
- `s3`  out  1  to decoder S3; 1 suppresses normal-glyph segments
- `an_n`  out  N_DIGITS  active-low digit enables, at most one low
- `err_mask`  out  N_DIGITS  bit i = digit i loaded with invalid code
- `err_any`  out  1  OR of err_mask

## Operation
- Digit file: per digit a 5-bit code and a `loaded` bit. On reset or `clr`, all codes = 0 and loaded = 0.
- Write (`wr_en`, valid addr): code[addr] ← wr_code, loaded[addr] ← 1, err_mask[addr] ← (popcount(wr_code) ≠ 2). Visible in registers the next cycle.
- `clr` and `wr_en` in the same cycle: `clr` wins.
- Scan FSM states:
  - DEAD: all `an_n` = 1, `s3` = 1, `e_out` = 0. Lasts exactly 1 cycle. On exit, the current digit's code and loaded bit are latched into a shadow register.
  - ON: `e_out` = shadow code. `s3` = 0. `an_n[idx]` = 0 only if shadow loaded and `blank` = 0. Lasts PRESCALE−1 cycles.
  - At the end of ON: idx ← idx+1, wrapping N_DIGITS−1 → 0, and the FSM returns to DEAD.
- Invalid codes are still driven. The decoder shows its error glyph, which it emits regardless of `s3`.
- A write to the currently displayed digit takes effect at that digit's next slot, not mid-slot. This is because `e_out` comes from the shadow register.
- Unloaded digits: anode stays off, and the digit is never flagged as an error.
- `blank` acts combinationally on the gating only (registered `an_n` updated next cycle). The scan keeps running while blanked.

## Timing
- Reset values: idx = 0, FSM = DEAD, prescaler = 0, `an_n` all 1, `s3` = 1, `e_out` = 0, `err_mask` = 0, `err_any` = 0.
- All outputs are registered; `blank`, `wr_*` and `clr` affect outputs 1 cycle later.
- Slot period is exactly PRESCALE cycles. A full refresh frame is N_DIGITS×PRESCALE cycles.
- First anode assertion after reset release: cycle 2 (DEAD at cycle 1, ON registered at cycle 2), for digit 0.
- `err_mask` and `err_any` update the cycle after the write. `clr` zeroes both the cycle after it is sampled.
- Reset asserted mid-slot: everything returns asynchronously to reset values. No partial slot resumes.

## Structure
- Shared package `display_pkg`:
  - code width constant `CODE_W = 5`
  - `scan_state_t` enum {DEAD, ON}
  - function `is_2of5(code)` (popcount == 2)
- One sub-module, `scan_prescaler`: counter 0..PRESCALE−1 with a terminal-count pulse and a slot-start pulse.
- Digit file, FSM and output registers live in the top module.
- The existing segment decoder is instantiated by the parent, not inside this block.

## Test plan
- Reset then idle, N=4, PRESCALE=4, nothing written: `an_n` stays 4'b1111 forever, `err_any` = 0, `s3` pulses 1 for one cycle every 4 cycles.
- Write codes 5'b11000, 01100, 00110, 00011 to digits 0..3 → `an_n` cycles 1110, 1101, 1011, 0111. Each is low for 3 cycles with `e_out` matching, separated by one all-ones cycle. Frame = 16 cycles.
- Write 5'b10101 to digit 2 → next cycle `err_mask` = 4'b0100 and `err_any` = 1. Digit 2 is still scanned with `e_out` = 10101. Rewriting 5'b10100 clears the bit.
- Write digit 1 while digit 1 is in ON: `e_out` keeps the old code until that slot ends, and the new code appears one frame later.
- `blank` high for 10 cycles mid-frame → `an_n` = all ones one cycle later through 1 cycle after release. idx advancement is unchanged.
- `clr` together with `wr_en` to digit 0, and async reset during ON of digit 3 → all digits unloaded and outputs at reset values immediately. The scan restarts at digit 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the 2-of-5 seven-segment display path.
package display_pkg;

    localparam int CODE_W = 5;

    typedef enum logic {
        DEAD = 1'b0,
        ON   = 1'b1
    } scan_state_t;

    // A legal 2-of-5 word has exactly two bits set.
    function automatic logic is_2of5(input logic [CODE_W-1:0] code);
        return ($countones(code) == 2);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running slot counter: counts 0..PRESCALE-1 and flags the first and last cycle of each slot.
module scan_prescaler #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic terminal,
    output logic slot_start
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] count;

    // Count up and wrap to zero after the last cycle of the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == CW'(PRESCALE - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign terminal   = (count == CW'(PRESCALE - 1));
    assign slot_start = (count == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller feeding one shared 2-of-5 segment decoder.
// Each slot is one dead cycle followed by PRESCALE-1 lit cycles; the lit code
// comes from a shadow register so writes never change a digit mid-slot.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [$clog2(N_DIGITS)-1:0] wr_addr,
    input  logic [CODE_W-1:0]           wr_code,
    input  logic                        blank,
    input  logic                        clr,
    output logic [CODE_W-1:0]           e_out,
    output logic                        s3,
    output logic [N_DIGITS-1:0]         an_n,
    output logic [N_DIGITS-1:0]         err_mask,
    output logic                        err_any
);

    localparam int AW = $clog2(N_DIGITS);

    logic [CODE_W-1:0]   code_file [N_DIGITS];
    logic [N_DIGITS-1:0] loaded;
    logic [N_DIGITS-1:0] err_next;
    logic                addr_ok;
    logic                write_ok;

    scan_state_t         state;
    scan_state_t         next_state;
    logic [AW-1:0]       idx;
    logic [CODE_W-1:0]   shadow_code;
    logic                shadow_loaded;
    logic                terminal;
    logic                slot_start;

    logic [N_DIGITS-1:0] an_d;
    logic                s3_d;
    logic [CODE_W-1:0]   e_d;

    assign addr_ok  = ({1'b0, wr_addr} < (AW + 1)'(N_DIGITS));
    assign write_ok = wr_en && addr_ok && !clr;

    scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .terminal   (terminal),
        .slot_start (slot_start)
    );

    // Digit file: clear wins over a simultaneous write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                code_file[i] <= '0;
            end
            loaded <= '0;
        end else if (clr) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                code_file[i] <= '0;
            end
            loaded <= '0;
        end else if (write_ok) begin
            code_file[wr_addr] <= wr_code;
            loaded[wr_addr]    <= 1'b1;
        end
    end

    // Next error mask, so err_any can be registered in the same cycle as err_mask.
    always_comb begin
        err_next = err_mask;
        if (clr) begin
            err_next = '0;
        end else if (write_ok) begin
            err_next[wr_addr] = !is_2of5(wr_code);
        end
    end

    // Error flags are only ever set by a write, so unloaded digits stay clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_mask <= '0;
            err_any  <= 1'b0;
        end else begin
            err_mask <= err_next;
            err_any  <= |err_next;
        end
    end

    // Scan state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DEAD;
        end else begin
            state <= next_state;
        end
    end

    // One dead cycle at slot start, then lit until the prescaler's last count.
    always_comb begin
        next_state = state;
        unique case (state)
            DEAD:    next_state = slot_start ? ON : DEAD;
            ON:      next_state = terminal ? DEAD : ON;
            default: next_state = DEAD;
        endcase
    end

    // Advance to the next digit as each lit phase ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (state == ON && terminal) begin
            idx <= (idx == AW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end

    // Snapshot the current digit when leaving the dead cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_code   <= '0;
            shadow_loaded <= 1'b0;
        end else if (state == DEAD && next_state == ON) begin
            shadow_code   <= code_file[idx];
            shadow_loaded <= loaded[idx];
        end
    end

    // Output decode: dark and suppressed while dead, shadow code while lit.
    always_comb begin
        an_d = '1;
        s3_d = 1'b1;
        e_d  = '0;
        if (state == ON) begin
            s3_d = 1'b0;
            e_d  = shadow_code;
            if (shadow_loaded && !blank) begin
                an_d[idx] = 1'b0;
            end
        end
    end

    // Register all decoder and anode outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n  <= '1;
            s3    <= 1'b1;
            e_out <= '0;
        end else begin
            an_n  <= an_d;
            s3    <= s3_d;
            e_out <= e_d;
        end
    end

endmodule
